// File: rtl/align_offset_detect.sv
// align_offset_detect: measures the signed cycle offset (k_data - k_ref) between
// a reference rising edge on ref_en_i and a thresholded data event, and
// publishes it as a 32-bit two's-complement align_set_o word.
// Optional build macro ALIGN_AVG4_EN: one start pulse collects four offsets and
// reports their arithmetic mean (sum >>> 2).
module align_offset_detect #(
  parameter real         TCQ         = 0.1,
  parameter int unsigned ALIGN_WIDTH = 32,
  parameter int unsigned TIMEOUT     = 16383
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   measure_start_i,
  input  logic                   ref_en_i,
  input  logic                   data_en_i,
  input  logic [ALIGN_WIDTH-1:0] data_i,
  input  logic [ALIGN_WIDTH-1:0] data_thresh_i,
  output logic [31:0]            align_set_o,
  output logic                   align_valid_o,
  output logic                   align_busy_o,
  output logic                   align_timeout_o,
  output logic                   align_sat_o
);

  localparam int unsigned CNT_W = 15;
  localparam int unsigned SET_W = 32;
  localparam logic [CNT_W-1:0] MAG_MAX   = CNT_W'(16383);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  // The 15-bit counter must be able to reach TIMEOUT without wrapping.
  if (TCQ < 0.0 || TIMEOUT < 1 || TIMEOUT > 32767) begin : g_param_check
    $error("align_offset_detect: TCQ must be >= 0 and TIMEOUT in 1..32767");
  end

  typedef enum logic [2:0] {IDLE, ARMED, WAIT_DATA, WAIT_REF, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ref_q;
  logic [SET_W-1:0]  set_d;
  logic              valid_d, busy_d, timeout_d, sat_d;

  logic              ref_evt, data_evt;
  logic              clamp;
  logic [CNT_W-1:0]  mag;
  logic [SET_W-1:0]  off_pos, off_neg;
  logic              done_hit;
  logic [SET_W-1:0]  done_off;
  logic              done_sat;

  assign ref_evt  = ref_en_i & ~ref_q;
  assign data_evt = data_en_i & (data_i >= data_thresh_i);

  // Clamp the elapsed-cycle magnitude and form both signed offsets.
  always_comb begin
    clamp   = (cnt_q > MAG_MAX);
    mag     = clamp ? MAG_MAX : cnt_q;
    off_pos = SET_W'(mag);
    off_neg = SET_W'(0) - SET_W'(mag);
  end

`ifdef ALIGN_AVG4_EN
  localparam int unsigned ACC_W = SET_W + 2;
  logic signed [ACC_W-1:0] acc_q, acc_d, acc_sum;
  logic [1:0]              smp_q, smp_d;
  logic                    sat_any_q, sat_any_d;
  logic [SET_W-1:0]        avg;
`endif

  // Next-state, counter and next-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    set_d     = align_set_o;
    valid_d   = 1'b0;
    busy_d    = align_busy_o;
    timeout_d = 1'b0;
    sat_d     = align_sat_o;
    done_hit  = 1'b0;
    done_off  = '0;
    done_sat  = 1'b0;
`ifdef ALIGN_AVG4_EN
    acc_d     = acc_q;
    smp_d     = smp_q;
    sat_any_d = sat_any_q;
    acc_sum   = '0;
    avg       = '0;
`endif
    if (measure_start_i) begin
      // Start or restart from any state; no pulses are produced.
      state_d = ARMED;
      cnt_d   = '0;
      busy_d  = 1'b1;
`ifdef ALIGN_AVG4_EN
      acc_d     = '0;
      smp_d     = '0;
      sat_any_d = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: ;
        ARMED: begin
          if (ref_evt && data_evt) begin
            done_hit = 1'b1;
          end else if (ref_evt) begin
            state_d = WAIT_DATA;
            cnt_d   = CNT_W'(1);
          end else if (data_evt) begin
            state_d = WAIT_REF;
            cnt_d   = CNT_W'(1);
          end
        end
        WAIT_DATA, WAIT_REF: begin
          if ((state_q == WAIT_DATA) ? data_evt : ref_evt) begin
            done_hit = 1'b1;
            done_off = (state_q == WAIT_DATA) ? off_pos : off_neg;
            done_sat = clamp;
          end else if (cnt_q >= CNT_LIMIT) begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            timeout_d = 1'b1;
`ifdef ALIGN_AVG4_EN
            acc_d     = '0;
            smp_d     = '0;
            sat_any_d = 1'b0;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase

`ifdef ALIGN_AVG4_EN
      acc_sum = acc_q + ACC_W'(signed'(done_off));
      avg     = SET_W'(acc_sum >>> 2);
      if (done_hit) begin
        if (smp_q == 2'd3) begin
          state_d   = DONE;
          busy_d    = 1'b0;
          valid_d   = 1'b1;
          set_d     = avg;
          sat_d     = sat_any_q | done_sat;
          acc_d     = '0;
          smp_d     = '0;
          sat_any_d = 1'b0;
        end else begin
          state_d   = ARMED;
          cnt_d     = '0;
          acc_d     = acc_sum;
          smp_d     = smp_q + 2'd1;
          sat_any_d = sat_any_q | done_sat;
        end
      end
`else
      if (done_hit) begin
        state_d = DONE;
        busy_d  = 1'b0;
        valid_d = 1'b1;
        set_d   = done_off;
        sat_d   = done_sat;
      end
`endif
    end
  end

  // State, counter, edge register and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      ref_q           <= 1'b0;
      align_set_o     <= '0;
      align_valid_o   <= 1'b0;
      align_busy_o    <= 1'b0;
      align_timeout_o <= 1'b0;
      align_sat_o     <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      ref_q           <= ref_en_i;
      align_set_o     <= set_d;
      align_valid_o   <= valid_d;
      align_busy_o    <= busy_d;
      align_timeout_o <= timeout_d;
      align_sat_o     <= sat_d;
    end
  end

`ifdef ALIGN_AVG4_EN
  // Averaging accumulator registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q     <= '0;
      smp_q     <= '0;
      sat_any_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      smp_q     <= smp_d;
      sat_any_q <= sat_any_d;
    end
  end
`endif

endmodule

// File: tb/tb_align_offset_detect.sv
// Self-checking bench for align_offset_detect (default build). Two instances:
// default TIMEOUT, and TIMEOUT=20000 for the clamp cases.
module tb_align_offset_detect;

  localparam int unsigned AW      = 32;
  localparam int unsigned TO_DEF  = 16383;
  localparam int unsigned TO_BIG  = 20000;
  localparam int          MAG_LIM = 16383;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, ms, ref_en, den;
  logic [AW-1:0] data, thr;
  logic [31:0]   set1, set2;
  logic          v1, v2, b1, b2, to1, to2, s1, s2;

  align_offset_detect #(.TCQ(0.1), .ALIGN_WIDTH(AW), .TIMEOUT(TO_DEF)) u_dut (
    .clk_i(clk), .rst_i(rst), .measure_start_i(ms), .ref_en_i(ref_en),
    .data_en_i(den), .data_i(data), .data_thresh_i(thr),
    .align_set_o(set1), .align_valid_o(v1), .align_busy_o(b1),
    .align_timeout_o(to1), .align_sat_o(s1)
  );

  align_offset_detect #(.TCQ(0.1), .ALIGN_WIDTH(AW), .TIMEOUT(TO_BIG)) u_dut_big (
    .clk_i(clk), .rst_i(rst), .measure_start_i(ms), .ref_en_i(ref_en),
    .data_en_i(den), .data_i(data), .data_thresh_i(thr),
    .align_set_o(set2), .align_valid_o(v2), .align_busy_o(b2),
    .align_timeout_o(to2), .align_sat_o(s2)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_set;
  logic        exp_sat;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a data word that is (evt=1) or is not (evt=0) a data event.
  task automatic drive_data(input bit evt);
    if (evt) begin
      den  = 1'b1;
      data = ($urandom_range(2, 0) == 0) ? thr : $urandom_range(32'hFFFF_FFFF, thr);
    end else if ($urandom_range(1, 0) == 1) begin
      den  = 1'b1;
      data = ($urandom_range(1, 0) == 1) ? thr - 32'd1 : $urandom_range(thr - 32'd1, 0);
    end else begin
      den  = 1'b0;
      data = $urandom_range(32'hFFFF_FFFF, thr);
    end
  endtask

  // Reference result: offset = data cycle - ref cycle, clamped to +-16383.
  function automatic void model(input int r, input int d, output logic [31:0] s, output logic sat);
    int off;
    off = d - r;
    sat = 1'b0;
    if (off > MAG_LIM) begin
      off = MAG_LIM;
      sat = 1'b1;
    end else if (off < -MAG_LIM) begin
      off = -MAG_LIM;
      sat = 1'b1;
    end
    s = 32'(off);
  endfunction

  // One measurement: start at t=0, ref rise at r, first data event at d.
  task automatic run_meas(input string name, input int r, input int d, input int pre_hi,
                          input bit extra, input bit big);
    int          m;
    logic [31:0] m_set, o_set;
    logic        m_sat, o_v, o_b, o_t, o_s;
    bit          ev;
    m = (r > d) ? r : d;
    model(r, d, m_set, m_sat);
    thr    = $urandom_range(32'hFFFF_FFF0, 1);
    ms     = 1'b0;
    ref_en = (pre_hi > 0);
    drive_data(1'b0);
    tick();
    for (int t = 0; t <= m + 2; t++) begin
      ms     = (t == 0);
      ref_en = (t < pre_hi) || (t >= r && !(extra && (r + 2 < d) && t == r + 1));
      ev     = (t == d) || (extra && d < r && t > d && t <= r && $urandom_range(1, 0) == 1);
      drive_data(ev);
      tick();
      o_set = big ? set2 : set1;
      o_v   = big ? v2 : v1;
      o_b   = big ? b2 : b1;
      o_t   = big ? to2 : to1;
      o_s   = big ? s2 : s1;
      if (t == m) begin
        exp_set = m_set;
        exp_sat = m_sat;
      end
      checks++;
      if (o_v !== (t == m)) begin
        errors++;
        $display("FAIL %s valid r=%0d d=%0d t=%0d got %b want %b", name, r, d, t, o_v, (t == m));
      end
      checks++;
      if (o_b !== (t < m)) begin
        errors++;
        $display("FAIL %s busy r=%0d d=%0d t=%0d got %b want %b", name, r, d, t, o_b, (t < m));
      end
      checks++;
      if (o_t !== 1'b0) begin
        errors++;
        $display("FAIL %s timeout r=%0d d=%0d t=%0d got %b want 0", name, r, d, t, o_t);
      end
      checks++;
      if (o_set !== exp_set) begin
        errors++;
        $display("FAIL %s set r=%0d d=%0d t=%0d got %h want %h", name, r, d, t, o_set, exp_set);
      end
      checks++;
      if (o_s !== exp_sat) begin
        errors++;
        $display("FAIL %s sat r=%0d d=%0d t=%0d got %b want %b", name, r, d, t, o_s, exp_sat);
      end
    end
    ms = 1'b0; ref_en = 1'b0; den = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; ms = 1'b0; ref_en = 1'b0; den = 1'b0; data = '0; thr = 32'd1;
    tick();
    tick();
    checks++;
    if ({set1, v1, b1, to1, s1} !== 36'd0) begin
      errors++;
      $display("FAIL reset outputs got set=%h v=%b b=%b to=%b s=%b want all 0", set1, v1, b1, to1, s1);
    end
    checks++;
    if ({set2, v2, b2, to2, s2} !== 36'd0) begin
      errors++;
      $display("FAIL reset_big outputs got set=%h v=%b b=%b to=%b s=%b want all 0", set2, v2, b2, to2, s2);
    end
    rst = 1'b0;
    exp_set = '0;
    exp_sat = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    run_meas("ref_then_data", 10, 35, 0, 1'b0, 1'b0);
    run_meas("data_then_ref", 18, 10, 0, 1'b0, 1'b0);
    run_meas("same_cycle", 7, 7, 0, 1'b0, 1'b0);
    run_meas("ref_high_at_arm", 12, 20, 6, 1'b0, 1'b0);
    run_meas("repeat_ref", 5, 20, 0, 1'b1, 1'b0);
    run_meas("repeat_data", 20, 6, 0, 1'b1, 1'b0);
  endtask

  task automatic test_restart();
    thr = $urandom_range(32'hFFFF_FFF0, 1);
    ms = 1'b0; ref_en = 1'b0; drive_data(1'b0);
    tick();
    for (int t = 0; t <= 22; t++) begin
      ms     = (t == 0) || (t == 8);
      ref_en = (t >= 3 && t < 10) || (t >= 20);
      drive_data(t == 12);
      tick();
      if (t == 20) begin
        exp_set = 32'hFFFF_FFF8;
        exp_sat = 1'b0;
      end
      checks++;
      if (v1 !== (t == 20) || to1 !== 1'b0) begin
        errors++;
        $display("FAIL restart pulses t=%0d got v=%b to=%b want v=%b to=0", t, v1, to1, (t == 20));
      end
      checks++;
      if (b1 !== (t < 20) || set1 !== exp_set || s1 !== exp_sat) begin
        errors++;
        $display("FAIL restart state t=%0d got b=%b set=%h s=%b want b=%b set=%h s=%b",
                 t, b1, set1, s1, (t < 20), exp_set, exp_sat);
      end
    end
    ms = 1'b0; ref_en = 1'b0; den = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int r, to_t;
    r    = 5;
    to_t = r + int'(TO_DEF);
    thr  = $urandom_range(32'hFFFF_FFF0, 1);
    ms = 1'b0; ref_en = 1'b0; drive_data(1'b0);
    tick();
    for (int t = 0; t <= to_t + 2; t++) begin
      ms     = (t == 0);
      ref_en = (t >= r);
      drive_data(1'b0);
      tick();
      checks++;
      if (to1 !== (t == to_t) || v1 !== 1'b0) begin
        errors++;
        $display("FAIL timeout pulses t=%0d got to=%b v=%b want to=%b v=0", t, to1, v1, (t == to_t));
      end
      checks++;
      if (b1 !== (t < to_t) || set1 !== exp_set || s1 !== exp_sat) begin
        errors++;
        $display("FAIL timeout state t=%0d got b=%b set=%h s=%b want b=%b set=%h s=%b",
                 t, b1, set1, s1, (t < to_t), exp_set, exp_sat);
      end
    end
    ms = 1'b0; ref_en = 1'b0; den = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    thr = $urandom_range(32'hFFFF_FFF0, 1);
    ms = 1'b0; ref_en = 1'b0; drive_data(1'b0);
    tick();
    for (int t = 0; t <= 30; t++) begin
      ms     = (t == 0);
      ref_en = (t >= 5);
      rst    = (t == 9);
      drive_data(t == 9 || t == 12 || t == 15);
      tick();
      if (t == 9) begin
        exp_set = '0;
        exp_sat = 1'b0;
      end
      checks++;
      if (v1 !== 1'b0 || to1 !== 1'b0 || b1 !== (t < 9)) begin
        errors++;
        $display("FAIL reset_mid ctl t=%0d got v=%b to=%b b=%b want v=0 to=0 b=%b", t, v1, to1, b1, (t < 9));
      end
      checks++;
      if (set1 !== exp_set || s1 !== exp_sat) begin
        errors++;
        $display("FAIL reset_mid data t=%0d got set=%h s=%b want set=%h s=%b", t, set1, s1, exp_set, exp_sat);
      end
    end
    rst = 1'b0; ref_en = 1'b0; den = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int r, d, pre;
    bit ex;
    for (int i = 0; i < 30; i++) begin
      r   = int'($urandom_range(40, 1));
      d   = int'($urandom_range(40, 1));
      pre = (r >= 2 && $urandom_range(3, 0) == 0) ? int'($urandom_range(r - 1, 1)) : 0;
      ex  = 1'($urandom_range(1, 0));
      run_meas("random", r, d, pre, ex, 1'b0);
    end
  endtask

  task automatic test_saturation();
    rst = 1'b1; ms = 1'b0; ref_en = 1'b0; den = 1'b0;
    tick();
    rst = 1'b0;
    exp_set = '0;
    exp_sat = 1'b0;
    run_meas("sat_pos", 3, 17003, 0, 1'b0, 1'b1);
    run_meas("sat_neg", 16387, 3, 0, 1'b0, 1'b1);
    run_meas("edge_16383", 2, 16385, 0, 1'b0, 1'b1);
    run_meas("sat_clear", 5, 9, 0, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_restart();
    test_timeout();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/align_offset_detect.md
ALIGN_OFFSET_DETECT -- requirements
Module: align_offset_detect

Interface
REQ-001 The block SHALL have parameter TCQ, default 0.1, meaning register clock-to-Q delay in ns.
REQ-002 The block SHALL have parameter ALIGN_WIDTH, default 32, meaning data word width.
REQ-003 The block SHALL have parameter TIMEOUT, default 16383, meaning the maximum number of cycles between the two events.
REQ-004 The block SHALL have port clk_i  in  1  as its single clock; one clock; all logic SHALL be on its rising edge.
REQ-005 The block SHALL have port rst_i  in  1  as its reset; reset is synchronous and active-high.
REQ-006 The block SHALL have port measure_start_i  in  1  as a one-cycle pulse that arms a measurement.
REQ-007 The block SHALL have port ref_en_i  in  1  as the reference scan-start level, where its rising edge is the reference event.
REQ-008 The block SHALL have port data_en_i  in  1  as the data-valid qualifier.
REQ-009 The block SHALL have port data_i  in  ALIGN_WIDTH  as the data word.
REQ-010 The block SHALL have port data_thresh_i  in  ALIGN_WIDTH  as an unsigned threshold, where data_en_i && data_i >= data_thresh_i is the data event.
REQ-011 The block SHALL have port align_set_o  out  32  as the measured offset in two's complement, formatted for the align_set input of the alignment unit.
REQ-012 The block SHALL have port align_valid_o  out  1  as a one-cycle pulse when align_set_o updates.
REQ-013 The block SHALL have port align_busy_o  out  1  that is high while armed or measuring.
REQ-014 The block SHALL have port align_timeout_o  out  1  as a one-cycle pulse when a measurement is abandoned.
REQ-015 The block SHALL have port align_sat_o  out  1  as a sticky flag showing the last result was clamped.

Function
REQ-016 The block SHALL implement the FSM states IDLE, ARMED, WAIT_DATA (reference seen), WAIT_REF (data seen), and DONE.
REQ-017 The block SHALL detect the reference event with a registered previous value of ref_en_i, treating it as the rising edge; ref_en_i already high at arming SHALL NOT count as an event.
REQ-018 In IDLE, measure_start_i SHALL clear the 15-bit counter cnt, set busy, and move the FSM to ARMED.
REQ-019 In ARMED, a reference event alone SHALL move the FSM to WAIT_DATA, a data event alone SHALL move it to WAIT_REF, and both events in the same cycle SHALL move it to DONE with offset 0.
REQ-020 In WAIT_DATA and WAIT_REF, cnt SHALL increment by 1 per cycle starting at 1 on the cycle after the first event, so that a second event at cycle k1+N yields a magnitude of N.
REQ-021 The offset SHALL equal k_data − k_ref, which is +N from WAIT_DATA and −N from WAIT_REF, sign-extended to 32 bits.
REQ-022 Any offset magnitude above 16383 SHALL be clamped to ±16383 with align_sat_o set; otherwise align_sat_o SHALL be cleared on each result.
REQ-023 In DONE, the block SHALL register align_set_o, pulse align_valid_o, drop busy, and return to IDLE one cycle after DONE, so that align_valid_o occurs at cycle k2+1.
REQ-024 If cnt reaches TIMEOUT without the second event, the block SHALL pulse align_timeout_o, return to IDLE, leave align_set_o unchanged, and leave align_valid_o low.
REQ-025 Repeat events of the first-seen type while waiting SHALL be ignored.
REQ-026 measure_start_i in any non-IDLE state SHALL restart the measurement by clearing cnt and moving to ARMED, with no valid or timeout pulse.
REQ-027 align_set_o SHALL hold its value between measurements.

Reset
REQ-028 On rst_i high at any cycle, including mid-measurement, the FSM SHALL return to IDLE and cnt, align_set_o, align_valid_o, align_busy_o, align_timeout_o, align_sat_o, and the ref_en_i edge register SHALL all be set to 0.
REQ-029 No event SHALL be recognised in the cycle rst_i is high.

Configuration
REQ-030 When macro ALIGN_AVG4_EN is defined, each measurement SHALL accumulate four consecutive DONE offsets, armed by a single measure_start_i and re-arming internally after each, and SHALL output the arithmetic-shift-right-by-2 of the sum with one align_valid_o after the fourth.
REQ-031 With ALIGN_AVG4_EN defined, a timeout SHALL discard the partial sum, and align_sat_o SHALL be set if any sample was clamped.
REQ-032 When ALIGN_AVG4_EN is not defined, every DONE SHALL produce a result directly, with no accumulator logic.

Verification
REQ-033 The bench SHALL check: start, then ref rise at t=10 and data event at t=35 -> align_set_o=25 (0x00000019) with the valid pulse at t=36.
REQ-034 The bench SHALL check: start, then data event at t=10 and ref rise at t=18 -> align_set_o=−8 (0xFFFFFFF8) with align_sat_o=0.
REQ-035 The bench SHALL check: start, then ref rise and data event in the same cycle t -> align_set_o=0 with valid at t+1.
REQ-036 The bench SHALL check: start, then ref rise with no data event -> align_timeout_o pulse after 16383 cycles, with align_set_o holding its prior value and busy=0.
REQ-037 The bench SHALL check: TIMEOUT=20000 with a data event 17000 cycles after ref -> align_set_o=16383 and align_sat_o=1.
REQ-038 The bench SHALL check: rst_i asserted while in WAIT_DATA -> all outputs 0 on the next cycle, and a later data event produces no valid.
